// File: rtl/serial_adder_seq_pkg.sv
// serial_adder_seq_pkg
//   Shared definitions for the bit-serial add/subtract engine:
//   FSM state encoding and the default operand width.
package serial_adder_seq_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   Combinational 1-bit full adder; the only arithmetic in the serial
//   datapath.
//   Ports: a, b, cin -> s (a ^ b ^ cin), co (majority of the three inputs).
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Bit-serial add/subtract engine. A start pulse latches a and b; one
//   bit pair per clock runs through a full-adder cell, LSB first, and the
//   result word plus carry-out is published with a one-cycle done pulse.
//   Ports:
//     clk, rst_n           clock (rising edge), asynchronous active-low reset
//     start, sub, cin      operation request, subtract select, add carry-in
//     a, b                 WIDTH-bit operands, sampled with start
//     sum, cout            result word and final carry (sub: 1 = no borrow)
//     busy, done           processing flag, one-cycle result-valid pulse
//     ser_bit, ser_valid   per-cycle serial sum tap and its qualifier
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done,
   output logic             ser_bit,
   output logic             ser_valid
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic fa_s, fa_co;

   full_adder_cell u_fa (
      .a   (a_sr_q[0]),
      .b   (b_sr_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .co  (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         // DONE accepts a new start just like IDLE so operations can run
         // back to back without a dead cycle.
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               // Subtract is a + ~b + 1: invert b and seed the carry.
               a_sr_d  = a;
               b_sr_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign busy      = (state_q == RUN);
   assign ser_valid = (state_q == RUN);
   assign ser_bit   = (state_q == RUN) & fa_s;
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq
//   Directed bench for serial_adder_seq (WIDTH = 8). Stimulus pushes the
//   hand-computed result of each operation into a scoreboard queue; a
//   monitor pops and compares whenever done is seen. Latency, busy length,
//   serial tap, result hold, ignored mid-run start and async reset are
//   checked inline by the stimulus process.
module tb_serial_adder_seq;

   typedef struct {
      logic [7:0] s;
      logic       c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       sub_i = 1'b0;
   logic       cin_i = 1'b0;
   logic [7:0] a_i = '0;
   logic [7:0] b_i = '0;
   logic [7:0] sum;
   logic       cout, busy, done, ser_bit, ser_valid;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   logic       have_prev = 1'b0;
   logic [7:0] prev_sum = '0;
   logic [7:0] last_ser = '0;

   serial_adder_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub_i),
      .cin       (cin_i),
      .a         (a_i),
      .b         (b_i),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy),
      .done      (done),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_sum", int'(sum), int'(e.s));
            chk("sb_cout", int'(cout), int'(e.c));
         end
      end
   end

   // Issues one operation at the current negedge and waits for done.
   // glitch_at > 0 pulses start with different operands in that RUN cycle.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic cv,
                         input logic [7:0] es, input logic ec,
                         input int glitch_at);
      int cyc, bc, ns;
      logic [7:0] sg;
      a_i = av; b_i = bv; sub_i = sv; cin_i = cv; start = 1'b1;
      sb_q.push_back('{es, ec});
      cyc = 0; bc = 0; ns = 0; sg = '0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == glitch_at) begin
            a_i = 8'hAA; b_i = 8'h55; sub_i = 1'b1; cin_i = 1'b1; start = 1'b1;
         end
         if (cyc == 1 && have_prev) chk("sum_hold_run", int'(sum), int'(prev_sum));
         if (busy) bc++;
         if (ser_valid && ns < 8) begin
            sg[ns] = ser_bit;
            ns++;
         end
         if (done) break;
      end
      chk("latency_edges", cyc, 9);
      chk("busy_cycles", bc, 8);
      chk("ser_valid_cycles", ns, 8);
      last_ser  = sg;
      prev_sum  = es;
      have_prev = 1'b1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_sum", int'(sum), 0);
      chk("rst_outs", int'({cout, busy, done, ser_bit, ser_valid}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain add, then results hold through IDLE
      run_op(8'd100, 8'd55, 1'b0, 1'b0, 8'd155, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("sum_hold_idle", int'(sum), 155);
      chk("idle_busy_done", int'({busy, done}), 0);

      @(negedge clk);
      run_op(8'd255, 8'd0, 1'b0, 1'b1, 8'd0, 1'b1, 0);
      @(negedge clk);
      run_op(8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 0);

      // Subtract; cin must be ignored
      @(negedge clk);
      run_op(8'd7, 8'd5, 1'b1, 1'b0, 8'd2, 1'b1, 0);
      @(negedge clk);
      run_op(8'd7, 8'd5, 1'b1, 1'b1, 8'd2, 1'b1, 0);
      @(negedge clk);
      run_op(8'd5, 8'd7, 1'b1, 1'b1, 8'hFE, 1'b0, 0);

      // Serial tap, LSB first: 0,0,0,0,1,0,0,0
      @(negedge clk);
      run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 0);
      chk("ser_bits", int'(last_ser), 8'h10);

      // Start during RUN ignored, then two back-to-back starts in DONE
      @(negedge clk);
      run_op(8'd10, 8'd20, 1'b0, 1'b0, 8'd30, 1'b0, 3);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 0);
      run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'hDE, 1'b0, 0);

      // Reset in RUN cycle 4: outputs clear at once, no done pulse
      @(negedge clk);
      a_i = 8'd1; b_i = 8'd1; sub_i = 1'b0; cin_i = 1'b0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("busy_before_rst", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sum", int'(sum), 0);
      chk("midrst_outs", int'({cout, busy, done, ser_bit, ser_valid}), 0);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_done", int'(done), 0);
      end
      rst_n = 1'b1;
      prev_sum = '0;
      @(negedge clk);
      run_op(8'h3C, 8'h5A, 1'b0, 1'b1, 8'h97, 1'b0, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial add/subtract engine built around the 3-input full-adder sum cell (a ^ b ^ carry) used in the neighbouring half/full-adder stage.
- Latches two WIDTH-bit operands on a start pulse and presents one operand bit pair plus the running carry to the sum logic per clock.
- Accumulates the sum LSB-first and reports a word result with carry-out and a done pulse.
- Sits upstream of the top-level pin mapping; its outputs drive uo_out/uio_out in the wrapper.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; sampled on the rising edge.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- cin  input  1  carry-in for add; ignored when sub = 1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- sum  output  WIDTH  result word; valid from the done cycle until the next accepted start.
- cout  output  1  final carry out; for subtract, 1 means no borrow.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- ser_bit  output  1  sum bit produced this cycle; debug/serial tap.
- ser_valid  output  1  high in each cycle where ser_bit is meaningful.

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE.
  - sum, cout, busy, done, ser_bit, ser_valid are all 0.
  - Internal shift registers, carry flop and bit counter are cleared.
- State IDLE:
  - busy = 0.
  - start = 1 loads: A_sr = a; B_sr = sub ? ~b : b; carry = sub ? 1 : cin; cnt = 0.
  - Next state is RUN.
- State RUN:
  - busy = 1 and ser_valid = 1.
  - ser_bit = A_sr[0] ^ B_sr[0] ^ carry, combinational from current registers.
  - Each edge:
    - carry <= majority(A_sr[0], B_sr[0], carry).
    - A_sr and B_sr shift right by one.
    - Result register shifts right with ser_bit entering at the MSB.
    - cnt increments.
  - On the edge where cnt = WIDTH-1: sum <= completed result, cout <= new carry, next state DONE.
- State DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - start = 1 in DONE is accepted exactly as in IDLE, next state RUN (back-to-back operations).
  - Otherwise next state is IDLE.
- Latency:
  - start sampled at edge k gives RUN during cycles k+1 .. k+WIDTH.
  - done is high in the cycle following edge k+WIDTH.
  - Total latency is WIDTH+1 edges from start to done.
- start during RUN is ignored: no reload, operands and mode remain those latched at the accepted start.
- sum and cout hold their value through IDLE and during the next RUN until that operation's final edge updates them.
- Arithmetic:
  - Modulo 2^WIDTH; cout is bit WIDTH of the full sum.
  - Subtract is two's complement (a + ~b + 1).
- cnt width is clog2(WIDTH); no wrap occurs because the FSM leaves RUN at WIDTH-1.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs are cleared immediately.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Default WIDTH constant.
- One sub-module is natural: full_adder_cell.
  - Combinational; inputs a, b, cin; outputs s, co.
  - Instantiated once in RUN datapath.
- The FSM, counter and shift registers remain in serial_adder_seq.

Test Plan:
- Add, no carry: a = 100, b = 55, cin = 0, sub = 0 → done at start+9 edges, sum = 155, cout = 0, busy high exactly 8 cycles.
- Add with overflow and carry-in: a = 255, b = 0, cin = 1 → sum = 0, cout = 1; and a = 200, b = 100, cin = 0 → sum = 44, cout = 1.
- Subtract: a = 7, b = 5, sub = 1 → sum = 2, cout = 1; a = 5, b = 7, sub = 1 → sum = 0xFE, cout = 0; cin toggled has no effect.
- Serial tap: a = 0x0F, b = 0x01 → ser_bit sequence LSB-first 0,0,0,0,1,0,0,0 with ser_valid high for those 8 cycles, final sum = 0x10.
- Start while busy plus back-to-back:
  - Pulse start with new operands mid-RUN → ignored, first result is unchanged.
  - Start asserted in the DONE cycle → second operation begins next edge, second done follows 9 edges later.
- Reset mid-operation: drop rst_n at RUN cycle 4 → all outputs 0 asynchronously, no done pulse; after release, a fresh start computes correctly.
